// File: rtl/ahb_mem_responder.sv
// AHB single-master arbiter and word-addressed memory responder for the DMA port.
// Serves pipelined reads and writes with configurable wait states and a backdoor load port.
module ahb_mem_responder #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 1,
    parameter int GRANT_DELAY = 2
) (
    input  logic          I_HCLK,
    input  logic          I_HRESET,
    input  logic [31:0]   I_DMA_HADDR,
    input  logic [31:0]   I_DMA_HWDATA,
    input  logic [1:0]    I_DMA_HTRANS,
    input  logic [2:0]    I_DMA_HSIZE,
    input  logic [2:0]    I_DMA_HBURST,
    input  logic          I_DMA_HBUSREQ,
    input  logic          I_DMA_HWRITE,
    output logic [31:0]   O_DMA_HRDATA,
    output logic          O_DMA_HREADY,
    output logic          O_DMA_HGRANT,
    input  logic          I_MEM_WE,
    input  logic [AW-1:0] I_MEM_ADDR,
    input  logic [31:0]   I_MEM_WDATA,
    output logic [31:0]   O_MEM_RDATA,
    output logic [31:0]   O_WR_CNT
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] GD_INIT = 4'(GRANT_DELAY);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {G_IDLE, G_WAIT, G_GRANTED} gstate_t;

    logic [31:0]   mem [DEPTH];
    gstate_t       g_state;
    logic [3:0]    g_cnt;
    logic          hgrant;
    logic          hready;
    logic [31:0]   hrdata;
    logic [31:0]   wr_cnt;
    logic [3:0]    ws_cnt;
    logic          vld_p1;
    logic          wr_p1;
    logic [AW-1:0] idx_p1;
    logic [2:0]    size_p1;
    logic [1:0]    lane_p1;

    logic          addr_ok;
    logic          wr_done;
    logic          keep_grant;
    logic [AW-1:0] idx_a;
    logic [31:0]   wr_word;
    logic          unused_ok;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            3'b000:  return 4'b0001 << lane;
            3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    assign idx_a      = I_DMA_HADDR[AW+1:2];
    assign addr_ok    = hgrant && hready && I_DMA_HTRANS[1];
    assign wr_done    = vld_p1 && wr_p1 && hready;
    assign wr_word    = merge_lanes(mem[idx_p1], I_DMA_HWDATA, byte_en(size_p1, lane_p1));
    // Grant must outlive any data phase that is still waiting or about to start.
    assign keep_grant = (vld_p1 && !hready) || addr_ok;
    assign unused_ok  = ^{I_DMA_HBURST, I_DMA_HADDR[31:AW+2], I_DMA_HTRANS[0]};

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            g_state <= G_IDLE;
            g_cnt   <= '0;
            hgrant  <= 1'b0;
        end else begin
            case (g_state)
                G_IDLE: begin
                    if (I_DMA_HBUSREQ) begin
                        if (GRANT_DELAY == 0) begin
                            g_state <= G_GRANTED;
                            hgrant  <= 1'b1;
                        end else begin
                            g_state <= G_WAIT;
                            g_cnt   <= GD_INIT;
                        end
                    end
                end
                G_WAIT: begin
                    if (!I_DMA_HBUSREQ) begin
                        g_state <= G_IDLE;
                    end else if (g_cnt <= 4'd1) begin
                        g_state <= G_GRANTED;
                        hgrant  <= 1'b1;
                        g_cnt   <= '0;
                    end else begin
                        g_cnt <= g_cnt - 4'd1;
                    end
                end
                G_GRANTED: begin
                    if (!I_DMA_HBUSREQ && !keep_grant) begin
                        g_state <= G_IDLE;
                        hgrant  <= 1'b0;
                    end
                end
                default: begin
                    g_state <= G_IDLE;
                    hgrant  <= 1'b0;
                end
            endcase
        end
    end

    // Address phase -> data phase (p1) control
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            vld_p1 <= 1'b0;
            hready <= 1'b1;
            ws_cnt <= '0;
            hrdata <= '0;
            wr_cnt <= '0;
        end else begin
            if (wr_done) wr_cnt <= wr_cnt + 32'd1;
            if (hready) begin
                vld_p1 <= addr_ok;
                if (addr_ok) begin
                    if (WAIT_STATES == 0) begin
                        // Zero-wait read lands on the same edge a prior write retires.
                        if (!I_DMA_HWRITE)
                            hrdata <= (wr_done && idx_p1 == idx_a) ? wr_word : mem[idx_a];
                    end else begin
                        hready <= 1'b0;
                        ws_cnt <= WS_INIT;
                    end
                end
            end else if (ws_cnt == 4'd0) begin
                hready <= 1'b1;
                if (!wr_p1) hrdata <= mem[idx_p1];
            end else begin
                ws_cnt <= ws_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (addr_ok) begin
            idx_p1  <= idx_a;
            wr_p1   <= I_DMA_HWRITE;
            size_p1 <= I_DMA_HSIZE;
            lane_p1 <= I_DMA_HADDR[1:0];
        end
    end

    // AHB write is last so it overrides a same-index backdoor write.
    always_ff @(posedge I_HCLK) begin
        if (I_MEM_WE) mem[I_MEM_ADDR] <= I_MEM_WDATA;
        if (wr_done) mem[idx_p1] <= wr_word;
    end

    assign O_DMA_HRDATA = hrdata;
    assign O_DMA_HREADY = hready;
    assign O_DMA_HGRANT = hgrant;
    assign O_MEM_RDATA  = mem[I_MEM_ADDR];
    assign O_WR_CNT     = wr_cnt;

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench: instance a uses 1 wait state / grant delay 2, instance b is zero-wait / zero-delay.
module tb_ahb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] a_haddr, a_hwdata, a_hrdata, a_mem_wdata, a_mem_rdata, a_wr_cnt;
    logic [1:0]  a_htrans;
    logic [2:0]  a_hsize, a_hburst;
    logic        a_busreq, a_hwrite, a_hready, a_hgrant, a_mem_we;
    logic [9:0]  a_mem_addr;

    logic [31:0] b_haddr, b_hwdata, b_hrdata, b_mem_wdata, b_mem_rdata, b_wr_cnt;
    logic [1:0]  b_htrans;
    logic [2:0]  b_hsize, b_hburst;
    logic        b_busreq, b_hwrite, b_hready, b_hgrant, b_mem_we;
    logic [9:0]  b_mem_addr;

    ahb_mem_responder #(.AW(10), .WAIT_STATES(1), .GRANT_DELAY(2)) u_a (
        .I_HCLK(clk), .I_HRESET(rst),
        .I_DMA_HADDR(a_haddr), .I_DMA_HWDATA(a_hwdata), .I_DMA_HTRANS(a_htrans),
        .I_DMA_HSIZE(a_hsize), .I_DMA_HBURST(a_hburst), .I_DMA_HBUSREQ(a_busreq),
        .I_DMA_HWRITE(a_hwrite), .O_DMA_HRDATA(a_hrdata), .O_DMA_HREADY(a_hready),
        .O_DMA_HGRANT(a_hgrant), .I_MEM_WE(a_mem_we), .I_MEM_ADDR(a_mem_addr),
        .I_MEM_WDATA(a_mem_wdata), .O_MEM_RDATA(a_mem_rdata), .O_WR_CNT(a_wr_cnt)
    );

    ahb_mem_responder #(.AW(10), .WAIT_STATES(0), .GRANT_DELAY(0)) u_b (
        .I_HCLK(clk), .I_HRESET(rst),
        .I_DMA_HADDR(b_haddr), .I_DMA_HWDATA(b_hwdata), .I_DMA_HTRANS(b_htrans),
        .I_DMA_HSIZE(b_hsize), .I_DMA_HBURST(b_hburst), .I_DMA_HBUSREQ(b_busreq),
        .I_DMA_HWRITE(b_hwrite), .O_DMA_HRDATA(b_hrdata), .O_DMA_HREADY(b_hready),
        .O_DMA_HGRANT(b_hgrant), .I_MEM_WE(b_mem_we), .I_MEM_ADDR(b_mem_addr),
        .I_MEM_WDATA(b_mem_wdata), .O_MEM_RDATA(b_mem_rdata), .O_WR_CNT(b_wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        a_haddr = '0; a_hwdata = '0; a_htrans = 2'b00; a_hsize = 3'b010; a_hburst = '0;
        a_busreq = 1'b0; a_hwrite = 1'b0; a_mem_we = 1'b0; a_mem_addr = '0; a_mem_wdata = '0;
        b_haddr = '0; b_hwdata = '0; b_htrans = 2'b00; b_hsize = 3'b010; b_hburst = '0;
        b_busreq = 1'b0; b_hwrite = 1'b0; b_mem_we = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;

        tick(); tick();
        chk("a_rst_grant", 32'(a_hgrant), 32'd0);
        chk("a_rst_ready", 32'(a_hready), 32'd1);
        chk("a_rst_rdata", a_hrdata, 32'd0);
        chk("a_rst_wrcnt", a_wr_cnt, 32'd0);
        chk("b_rst_ready", 32'(b_hready), 32'd1);
        rst = 1'b0;

        // Backdoor preload
        a_mem_we = 1'b1; a_mem_addr = 10'd4; a_mem_wdata = 32'hDEADBEEF;
        tick();
        a_mem_we = 1'b0;
        chk("a_bd_rd4", a_mem_rdata, 32'hDEADBEEF);

        // Grant after two held cycles
        a_busreq = 1'b1;
        tick();
        chk("a_gnt_c0", 32'(a_hgrant), 32'd0);
        chk("a_gnt_c0_rdy", 32'(a_hready), 32'd1);
        chk("a_gnt_c0_rd", a_hrdata, 32'd0);
        tick();
        chk("a_gnt_c1", 32'(a_hgrant), 32'd0);
        tick();
        chk("a_gnt_c2", 32'(a_hgrant), 32'd1);
        chk("a_gnt_c2_rdy", 32'(a_hready), 32'd1);

        // Single wait-state read
        a_haddr = 32'h10; a_htrans = 2'b10; a_hwrite = 1'b0; a_hsize = 3'b010;
        tick();
        a_htrans = 2'b00;
        chk("a_rd_wait", 32'(a_hready), 32'd0);
        tick();
        chk("a_rd_ready", 32'(a_hready), 32'd1);
        chk("a_rd_data", a_hrdata, 32'hDEADBEEF);
        tick();
        chk("a_rd_idle_rdy", 32'(a_hready), 32'd1);
        chk("a_rd_hold", a_hrdata, 32'hDEADBEEF);

        // Write with request dropped during its data phase
        a_haddr = 32'h14; a_htrans = 2'b10; a_hwrite = 1'b1;
        tick();
        chk("a_wr_wait", 32'(a_hready), 32'd0);
        a_htrans = 2'b00; a_busreq = 1'b0; a_hwrite = 1'b0; a_hwdata = 32'hCAFEF00D;
        tick();
        chk("a_wr_gnt_hold", 32'(a_hgrant), 32'd1);
        chk("a_wr_ready", 32'(a_hready), 32'd1);
        chk("a_wr_cnt0", a_wr_cnt, 32'd0);
        tick();
        a_mem_addr = 10'd5;
        chk("a_wr_gnt_drop", 32'(a_hgrant), 32'd0);
        chk("a_wr_cnt1", a_wr_cnt, 32'd1);
        #1;
        chk("a_wr_mem5", a_mem_rdata, 32'hCAFEF00D);

        // Request withdrawn mid-WAIT never grants
        a_busreq = 1'b1;
        tick();
        a_busreq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_wait_abort", 32'(a_hgrant), 32'd0);
        end

        // Reset during a read wait state
        a_busreq = 1'b1;
        tick(); tick(); tick();
        chk("a_regnt", 32'(a_hgrant), 32'd1);
        a_haddr = 32'h10; a_htrans = 2'b10; a_hwrite = 1'b0;
        tick();
        a_htrans = 2'b00;
        chk("a_rst_rd_wait", 32'(a_hready), 32'd0);
        rst = 1'b1; a_busreq = 1'b0; a_mem_addr = 10'd4;
        #1;
        chk("a_arst_ready", 32'(a_hready), 32'd1);
        chk("a_arst_grant", 32'(a_hgrant), 32'd0);
        chk("a_arst_rdata", a_hrdata, 32'd0);
        chk("a_arst_mem4", a_mem_rdata, 32'hDEADBEEF);
        tick();
        rst = 1'b0;
        tick();

        // Zero-delay grant on instance b
        b_busreq = 1'b1;
        tick();
        chk("b_gnt", 32'(b_hgrant), 32'd1);

        // Pipelined 4-beat word write burst
        b_hwrite = 1'b1; b_hsize = 3'b010; b_hburst = 3'b011;
        for (int i = 0; i < 5; i++) begin
            b_haddr  = 32'h20 + 32'(4 * i);
            b_htrans = (i == 0) ? 2'b10 : ((i == 4) ? 2'b00 : 2'b11);
            if (i > 0) b_hwdata = 32'(i - 1);
            tick();
            chk("b_burst_rdy", 32'(b_hready), 32'd1);
            chk("b_burst_cnt", b_wr_cnt, 32'(i));
        end
        b_hwrite = 1'b0; b_hburst = 3'b000;
        for (int i = 0; i < 4; i++) begin
            b_mem_addr = 10'(8 + i);
            #1;
            chk("b_burst_mem", b_mem_rdata, 32'(i));
        end

        // Read immediately after write to the same word
        b_haddr = 32'h30; b_htrans = 2'b10; b_hwrite = 1'b1;
        tick();
        b_hwrite = 1'b0; b_hwdata = 32'h55AA1234;
        tick();
        b_htrans = 2'b00;
        chk("b_raw_data", b_hrdata, 32'h55AA1234);

        // Byte then halfword write into a preloaded word
        b_mem_we = 1'b1; b_mem_addr = 10'd0; b_mem_wdata = 32'hFFFFFFFF;
        tick();
        b_mem_we = 1'b0;
        b_haddr = 32'h02; b_htrans = 2'b10; b_hwrite = 1'b1; b_hsize = 3'b000;
        tick();
        b_haddr = 32'h00; b_hsize = 3'b001; b_hwdata = 32'h77127777;
        tick();
        b_htrans = 2'b00; b_hwrite = 1'b0; b_hsize = 3'b010; b_hwdata = 32'h9999ABCD;
        tick();
        b_mem_addr = 10'd0;
        #1;
        chk("b_lane_mem0", b_mem_rdata, 32'hFF12ABCD);

        // Address wrap: 0x102C maps to word index 11
        b_haddr = 32'h102C; b_htrans = 2'b10; b_hwrite = 1'b0;
        tick();
        b_htrans = 2'b00;
        chk("b_wrap_rd", b_hrdata, 32'd3);

        // AHB write and backdoor write to the same index on the same edge
        b_haddr = 32'h3C; b_htrans = 2'b10; b_hwrite = 1'b1;
        tick();
        b_htrans = 2'b00; b_hwrite = 1'b0; b_hwdata = 32'hA5A5A5A5;
        b_mem_we = 1'b1; b_mem_addr = 10'd15; b_mem_wdata = 32'h11111111;
        tick();
        b_mem_we = 1'b0;
        #1;
        chk("b_collide_mem", b_mem_rdata, 32'hA5A5A5A5);
        chk("b_final_cnt", b_wr_cnt, 32'd8);

        b_busreq = 1'b0;
        tick();
        chk("b_gnt_drop", 32'(b_hgrant), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
- AHB slave-side responder and single-master arbiter for the rotation block's DMA master port.
- Grants the bus on request, decodes pipelined AHB transfers, and serves reads and writes from an internal word-addressed memory with configurable wait states.
- Used as the image source/destination memory in rotation simulations and FPGA bring-up.
- Sits on the DMA bus opposite the rotation core and is preloaded through a backdoor port.

Parameters:
- AW, 10, memory depth is 2**AW 32-bit words, indexed by HADDR[AW+1:2].
- WAIT_STATES, 1, number of HREADY-low cycles inserted per NONSEQ/SEQ data phase (0..15).
- GRANT_DELAY, 2, number of cycles HBUSREQ must be held before HGRANT asserts (0..15).

Ports:
- I_HCLK  in  1  bus clock; all logic on its rising edge.
- I_HRESET  in  1  asynchronous active-high reset.
- I_DMA_HADDR  in  32  master address.
- I_DMA_HWDATA  in  32  master write data (data phase).
- I_DMA_HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- I_DMA_HSIZE  in  3  000 byte, 001 halfword, 010 word.
- I_DMA_HBURST  in  3  burst type; informational only, addresses are taken per beat.
- I_DMA_HBUSREQ  in  1  bus request.
- I_DMA_HWRITE  in  1  1 = write.
- O_DMA_HRDATA  out  32  read data.
- O_DMA_HREADY  out  1  transfer done / slave ready.
- O_DMA_HGRANT  out  1  bus grant.
- I_MEM_WE  in  1  backdoor write strobe.
- I_MEM_ADDR  in  AW  backdoor word index.
- I_MEM_WDATA  in  32  backdoor write data.
- O_MEM_RDATA  out  32  backdoor combinational read of mem[I_MEM_ADDR].
- O_WR_CNT  out  32  count of completed AHB write transfers.

Behaviour:
- Reset values: O_DMA_HGRANT=0, O_DMA_HREADY=1, O_DMA_HRDATA=0, O_WR_CNT=0, grant FSM=IDLE, no data phase pending.
- Memory contents are not reset. Reset mid-transfer aborts the transfer, and the pending write is not performed.

Grant FSM (IDLE, WAIT, GRANTED):
- IDLE -> WAIT when HBUSREQ=1; the counter loads GRANT_DELAY.
- If GRANT_DELAY=0, IDLE -> GRANTED directly, with HGRANT high on the next cycle.
- WAIT: the counter decrements each cycle while HBUSREQ=1, and the FSM goes to GRANTED when the counter reaches 0. HBUSREQ=0 in WAIT returns the FSM to IDLE.
- GRANTED: HGRANT=1. When HBUSREQ=0 and no data phase is pending, HGRANT drops on the next edge and the FSM returns to IDLE. Otherwise the grant holds until the last data phase completes with HREADY=1.

Address phase:
- Sampled on an edge where HGRANT=1, HREADY=1 and HTRANS[1]=1.
- Latches address, write, size and byte lane.
- IDLE and BUSY transfers get a zero-wait OKAY: HREADY stays 1 and there is no memory access.
- Transfers while not granted are ignored.

Data phase:
- HREADY is 0 for WAIT_STATES cycles, then 1 for one cycle.
- Reads: HRDATA = mem[latched index] while HREADY=1. HRDATA holds its last value otherwise.
- Writes: memory is updated from HWDATA on the edge ending the HREADY=1 cycle, and O_WR_CNT increments at that edge.
- With WAIT_STATES=0, back-to-back transfers complete one per cycle, fully pipelined.

Size and lanes (little-endian):
- Word: all 4 bytes.
- Halfword: bytes selected by HADDR[1].
- Byte: byte selected by HADDR[1:0].
- Unwritten lanes are unchanged. Reads always return the full word.
- HSIZE > 010 is treated as word.

Address range: addresses beyond 2**AW words wrap by index truncation.

Boundaries and simultaneous events:
- Read of a word written in the immediately preceding data phase returns the new value.
- A backdoor write and an AHB write on the same edge to the same index: the AHB write wins. To different indices, both are performed.
- O_WR_CNT wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then HBUSREQ=1 with GRANT_DELAY=2 -> HGRANT=0 for 2 cycles, then 1; HREADY=1 and HRDATA=0 throughout.
- Backdoor load mem[4]=0xDEADBEEF, then AHB NONSEQ word read of 0x10 with WAIT_STATES=1 -> HREADY low 1 cycle, then high with HRDATA=0xDEADBEEF.
- Burst of 4 word writes (NONSEQ + 3 SEQ) of 0x0..0x3 to 0x20..0x2C with WAIT_STATES=0 -> one transfer per cycle; backdoor reads mem[8..11]=0..3; O_WR_CNT=4.
- mem[0]=0xFFFFFFFF, then byte write of 0x12 at 0x02 followed by halfword write of 0xABCD at 0x00 -> mem[0]=0xFF12ABCD.
- HBUSREQ dropped mid-WAIT -> FSM returns to IDLE and HGRANT never asserts. HBUSREQ dropped during a pending write data phase -> HGRANT holds until HREADY=1, then drops.
- Assert I_HRESET during a read data phase with HREADY=0 -> HREADY=1, HGRANT=0, HRDATA=0 immediately; memory contents are unchanged.
